// File: rtl/sha_msg_padder.sv
// sha_msg_padder: SHA-256 message padder and block issuer.
// Packs a big-endian 32-bit word stream into 512-bit blocks and appends the
// 0x80 marker, zero fill and 64-bit bit length. Blocks are strobed one cycle
// each. A chained block must land exactly CHAIN_GAP cycles after its
// predecessor. The first block of a message waits at least NEW_GAP cycles.
// Optional macro SHA_PAD_BYTE_EN: honour s_bytes on the final word. When it is
// not defined, every final word counts as four bytes.
module sha_msg_padder #(
    parameter int LEN_W     = 32,
    parameter int CHAIN_GAP = 64,
    parameter int NEW_GAP   = 65
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_last,
    input  logic [1:0]   s_bytes,
    output logic         m_valid,
    output logic [511:0] m_message,
    output logic         m_first,
    output logic         m_last,
    output logic         chain_err
);

    localparam int GAP_REQ = (NEW_GAP > CHAIN_GAP) ? NEW_GAP : CHAIN_GAP;
    localparam int GAP_W   = $clog2(GAP_REQ + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FILL   = 3'd1;
    localparam logic [2:0] ST_PAD    = 3'd2;
    localparam logic [2:0] ST_LENBLK = 3'd3;
    localparam logic [2:0] ST_FULL   = 3'd4;
    localparam logic [2:0] ST_DRAIN  = 3'd5;

    logic [2:0]        state;
    logic [0:15][31:0] asm_buf;     // word 0 sits in the MSBs, matching m_message
    logic [3:0]        idx;
    logic [LEN_W-1:0]  len_cnt;
    logic [GAP_W-1:0]  gap;
    logic              first_blk;   // ASM holds the first block of a message
    logic              final_blk;   // ASM holds the last block of a message
    logic              pad_next;    // 0x80 spilled past word 15 into the length block

    logic [2:0]        last_nb;
    logic              accept;
    logic              go;
    logic              issue;
    logic              issue_last;
    logic              underrun;
    logic [63:0]       len64;
    logic [4:0]        free_idx;
    logic [0:15][31:0] issue_msg;
    logic [0:15][31:0] tail_blk;

    // Saturating increment keeps the "long ago" state after reset or idle.
    function automatic logic [GAP_W-1:0] gap_sat_inc(input logic [GAP_W-1:0] g);
        gap_sat_inc = (&g) ? g : g + 1'b1;
    endfunction

    // Final word: keep nb leading bytes and drop the 0x80 marker right after them.
    function automatic logic [31:0] pad_word(input logic [31:0] d, input logic [2:0] nb);
        case (nb)
            3'd1:    pad_word = {d[31:24], 8'h80, 16'h0000};
            3'd2:    pad_word = {d[31:16], 8'h80, 8'h00};
            3'd3:    pad_word = {d[31:8], 8'h80};
            default: pad_word = d;
        endcase
    endfunction

    function automatic logic [63:0] len_field(input logic [LEN_W-1:0] l);
        len_field = 64'(l);
    endfunction

`ifdef SHA_PAD_BYTE_EN
    assign last_nb = (s_bytes == 2'd0) ? 3'd4 : {1'b0, s_bytes};
`else
    logic unused_bytes;
    assign last_nb      = 3'd4;
    assign unused_bytes = ^s_bytes;
`endif

    assign s_ready  = !reset && (state == ST_IDLE || state == ST_FILL || state == ST_DRAIN);
    assign accept   = s_valid && s_ready;
    assign len64    = len_field(len_cnt);
    assign free_idx = {1'b0, idx} + 5'd1 + ((last_nb == 3'd4) ? 5'd1 : 5'd0);
    assign underrun = (state == ST_FILL) && !first_blk && (gap == GAP_W'(CHAIN_GAP - 1));

    // Issue decision and the block image that goes out (PAD inserts the length on the fly).
    always_comb begin
        go         = first_blk ? (gap >= GAP_W'(NEW_GAP - 1)) : (gap == GAP_W'(CHAIN_GAP - 1));
        issue      = 1'b0;
        issue_last = final_blk;
        issue_msg  = asm_buf;
        tail_blk   = '0;
        tail_blk[0]  = pad_next ? 32'h8000_0000 : 32'h0000_0000;
        tail_blk[14] = len64[63:32];
        tail_blk[15] = len64[31:0];
        case (state)
            ST_PAD: begin
                issue         = go;
                issue_last    = 1'b1;
                issue_msg[14] = len64[63:32];
                issue_msg[15] = len64[31:0];
            end
            ST_LENBLK: begin
                issue      = go;
                issue_last = 1'b0;
            end
            ST_FULL: issue = go;
            default: ;
        endcase
    end

    // Output strobe, gap timing, and block assembly state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            asm_buf   <= '0;
            idx       <= '0;
            len_cnt   <= '0;
            gap       <= '1;
            first_blk <= 1'b1;
            final_blk <= 1'b0;
            pad_next  <= 1'b0;
            m_valid   <= 1'b0;
            m_first   <= 1'b0;
            m_last    <= 1'b0;
            m_message <= '0;
            chain_err <= 1'b0;
        end else begin
            m_valid <= issue;
            m_first <= issue && first_blk;
            m_last  <= issue && issue_last;
            if (issue) begin
                m_message <= issue_msg;
                gap       <= '0;
            end else begin
                gap <= gap_sat_inc(gap);
            end

            case (state)
                ST_IDLE, ST_FILL: begin
                    if (underrun) begin
                        // Chain slot missed: abandon the message and swallow its remainder.
                        chain_err <= 1'b1;
                        asm_buf   <= '0;
                        idx       <= '0;
                        len_cnt   <= '0;
                        first_blk <= 1'b1;
                        final_blk <= 1'b0;
                        pad_next  <= 1'b0;
                        state     <= (accept && s_last) ? ST_IDLE : ST_DRAIN;
                    end else if (accept) begin
                        if (s_last) begin
                            asm_buf[idx] <= pad_word(s_data, last_nb);
                            if (last_nb == 3'd4 && idx != 4'd15)
                                asm_buf[idx + 4'd1] <= 32'h8000_0000;
                            len_cnt  <= len_cnt + LEN_W'({last_nb, 3'b000});
                            pad_next <= (last_nb == 3'd4) && (idx == 4'd15);
                            idx      <= '0;
                            state    <= (free_idx <= 5'd14) ? ST_PAD : ST_LENBLK;
                        end else begin
                            asm_buf[idx] <= s_data;
                            len_cnt      <= len_cnt + LEN_W'(32);
                            idx          <= idx + 4'd1;
                            state        <= (idx == 4'd15) ? ST_FULL : ST_FILL;
                        end
                    end
                end
                ST_PAD: begin
                    if (issue) begin
                        asm_buf   <= '0;
                        len_cnt   <= '0;
                        first_blk <= 1'b1;
                        final_blk <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        asm_buf   <= issue_msg;
                        final_blk <= 1'b1;
                        state     <= ST_FULL;
                    end
                end
                ST_LENBLK: begin
                    if (issue) begin
                        asm_buf   <= tail_blk;
                        first_blk <= 1'b0;
                        final_blk <= 1'b1;
                        pad_next  <= 1'b0;
                        state     <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (issue) begin
                        asm_buf   <= '0;
                        if (final_blk) begin
                            len_cnt   <= '0;
                            first_blk <= 1'b1;
                            final_blk <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            first_blk <= 1'b0;
                            state     <= ST_FILL;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept && s_last)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_msg_padder.sv
// tb_sha_msg_padder: randomized bench for sha_msg_padder with a byte-level
// FIPS 180-4 padding model and strobe timing checks.
module tb_sha_msg_padder;

    localparam int LEN_W     = 32;
    localparam int CHAIN_GAP = 64;
    localparam int NEW_GAP   = 65;

    logic         clk = 1'b0;
    logic         reset;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         s_last;
    logic [1:0]   s_bytes;
    logic         m_valid;
    logic [511:0] m_message;
    logic         m_first;
    logic         m_last;
    logic         chain_err;

    sha_msg_padder #(.LEN_W(LEN_W), .CHAIN_GAP(CHAIN_GAP), .NEW_GAP(NEW_GAP)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .s_bytes(s_bytes), .m_valid(m_valid),
        .m_message(m_message), .m_first(m_first), .m_last(m_last), .chain_err(chain_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed strobes
    int unsigned  st_cyc[$];
    logic [511:0] st_msg[$];
    logic         st_first[$];
    logic         st_last[$];

    always @(negedge clk) begin
        if (m_valid === 1'b1) begin
            st_cyc.push_back(cyc);
            st_msg.push_back(m_message);
            st_first.push_back(m_first);
            st_last.push_back(m_last);
        end
    end

    // Expected blocks
    logic [511:0] exp_blk[$];
    logic         exp_first[$];
    logic         exp_last[$];

    int n_vec = 0;
    int n_err = 0;
    bit have_ref = 1'b0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int eff_bytes(input logic [1:0] b);
        int n;
        n = (b == 2'd0) ? 4 : int'(b);
`ifndef SHA_PAD_BYTE_EN
        n = 4;
`endif
        return n;
    endfunction

    // Reference: message bytes + 0x80 + zeros to 56 mod 64 + 8-byte length.
    task automatic add_expect(input logic [31:0] words[$], input logic [1:0] lbytes);
        byte unsigned      b[$];
        longint unsigned   bits;
        logic [31:0]       tmp;
        logic [511:0]      v;
        int                nb, cnt, nblk;
        nb = eff_bytes(lbytes);
        foreach (words[i]) begin
            tmp = words[i];
            cnt = (i == words.size() - 1) ? nb : 4;
            for (int k = 0; k < cnt; k++) b.push_back(tmp[31-8*k -: 8]);
        end
        bits = (longint'(b.size()) * 8) & ((64'd1 << LEN_W) - 1);
        b.push_back(8'h80);
        while (b.size() % 64 != 56) b.push_back(8'h00);
        for (int k = 7; k >= 0; k--) b.push_back(bits[8*k +: 8]);
        nblk = b.size() / 64;
        for (int j = 0; j < nblk; j++) begin
            v = '0;
            for (int k = 0; k < 64; k++) v[511-8*k -: 8] = b[64*j+k];
            exp_blk.push_back(v);
            exp_first.push_back(j == 0);
            exp_last.push_back(j == nblk - 1);
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] nbytes,
                             output int unsigned acc);
        int waitc;
        waitc   = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        s_bytes = nbytes;
        while (s_ready !== 1'b1) begin
            @(negedge clk);
            waitc++;
            if (waitc > 2000) begin
                $display("FAIL s_ready wait: got 0, expected 1 within 2000 cycles");
                $fatal(1, "source stuck");
            end
        end
        acc = cyc;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_msg(input logic [31:0] words[$], input logic [1:0] lbytes,
                            input int max_stall, output int unsigned last_acc);
        foreach (words[i]) begin
            if (i > 0 && max_stall > 0) repeat ($urandom_range(max_stall, 0)) @(negedge clk);
            send_word(words[i], i == words.size() - 1,
                      (i == words.size() - 1) ? lbytes : 2'd0, last_acc);
        end
    endtask

    task automatic check_msgs(input string name, input int base);
        int n, waitc;
        n = exp_blk.size();
        waitc = 0;
        while (st_cyc.size() < base + n && waitc < 400) begin
            @(negedge clk);
            waitc++;
        end
        chk({name, " strobe count"}, 512'(st_cyc.size()), 512'(base + n));
        if (st_cyc.size() >= base + n) begin
            for (int j = 0; j < n; j++) begin
                chk({name, " block"}, st_msg[base+j], exp_blk[j]);
                chk({name, " m_first"}, 512'(st_first[base+j]), 512'(exp_first[j]));
                chk({name, " m_last"}, 512'(st_last[base+j]), 512'(exp_last[j]));
                if (!exp_first[j])
                    chk({name, " chain spacing"}, 512'(st_cyc[base+j] - st_cyc[base+j-1]),
                        512'(CHAIN_GAP));
                else if (base + j > 0 && have_ref)
                    chk({name, " new-message spacing ok"},
                        512'((st_cyc[base+j] - st_cyc[base+j-1]) >= NEW_GAP), 512'(1));
                have_ref = 1'b1;
            end
        end
        repeat (140) @(negedge clk);
        chk({name, " no extra strobe"}, 512'(st_cyc.size()), 512'(base + n));
        exp_blk.delete();
        exp_first.delete();
        exp_last.delete();
    endtask

    initial begin
        logic [31:0]  w[$];
        logic [31:0]  w2[$];
        logic [1:0]   lb, lb2;
        logic [511:0] c;
        logic [511:0] tmpm;
        int unsigned  acc;
        int           base, len;

        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        s_bytes = '0;
        repeat (3) @(negedge clk);
        chk("reset s_ready", 512'(s_ready), 512'(0));
        chk("reset m_valid", 512'(m_valid), 512'(0));
        chk("reset m_first", 512'(m_first), 512'(0));
        chk("reset m_last", 512'(m_last), 512'(0));
        chk("reset chain_err", 512'(chain_err), 512'(0));
        chk("reset m_message", m_message, 512'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset s_ready", 512'(s_ready), 512'(1));

        // "abc"
        w = {32'h61626300};
        add_expect(w, 2'd3);
        base = st_cyc.size();
        send_msg(w, 2'd3, 0, acc);
        check_msgs("abc", base);
`ifdef SHA_PAD_BYTE_EN
        c = {32'h61626380, 448'd0, 32'h00000018};
`else
        c = {32'h61626300, 32'h80000000, 416'd0, 32'h00000020};
`endif
        if (st_cyc.size() > base) begin
            chk("abc fixed block", st_msg[base], c);
            chk("abc latency", 512'(st_cyc[base] - acc), 512'(2));
        end

        // 14 full words
        w = {};
        for (int i = 0; i < 14; i++) w.push_back($urandom);
        add_expect(w, 2'd0);
        base = st_cyc.size();
        send_msg(w, 2'd0, 0, acc);
        check_msgs("w14", base);
        if (st_cyc.size() > base + 1) begin
            tmpm = st_msg[base];
            chk("w14 blk0 words14-15", 512'(tmpm[63:0]), 512'(64'h80000000_00000000));
            chk("w14 blk1 fixed", st_msg[base+1], 512'h1C0);
            chk("w14 latency", 512'(st_cyc[base] - acc), 512'(2));
        end

        // 32 words, no stall
        w = {};
        for (int i = 0; i < 32; i++) w.push_back($urandom);
        add_expect(w, 2'd0);
        base = st_cyc.size();
        send_msg(w, 2'd0, 0, acc);
        check_msgs("w32", base);
        if (st_cyc.size() > base + 2) begin
            tmpm = st_msg[base+2];
            chk("w32 last word0", 512'(tmpm[511:480]), 512'(32'h80000000));
            chk("w32 last word15", 512'(tmpm[31:0]), 512'(32'h00000400));
            chk("w32 third strobe offset", 512'(st_cyc[base+2] - st_cyc[base]), 512'(128));
        end
        chk("w32 chain_err", 512'(chain_err), 512'(0));

        // Random messages with short source stalls
        for (int m = 0; m < 6; m++) begin
            len = $urandom_range(40, 1);
            w = {};
            for (int i = 0; i < len; i++) w.push_back($urandom);
            lb = 2'($urandom);
            add_expect(w, lb);
            base = st_cyc.size();
            send_msg(w, lb, 2, acc);
            check_msgs("random msg", base);
        end

        // Two back-to-back one-word messages
        w  = {$urandom};
        w2 = {$urandom};
        lb  = 2'($urandom);
        lb2 = 2'($urandom);
        add_expect(w, lb);
        add_expect(w2, lb2);
        base = st_cyc.size();
        send_msg(w, lb, 0, acc);
        send_msg(w2, lb2, 0, acc);
        check_msgs("b2b", base);

        // Chain underrun: 16 words, 70-cycle stall, 4 more words
        base = st_cyc.size();
        w = {};
        c = '0;
        for (int i = 0; i < 16; i++) begin
            w.push_back($urandom);
            c[511-32*i -: 32] = w[i];
        end
        for (int i = 0; i < 16; i++) send_word(w[i], 1'b0, 2'd0, acc);
        repeat (70) @(negedge clk);
        for (int i = 0; i < 4; i++) send_word($urandom, i == 3, 2'd0, acc);
        repeat (150) @(negedge clk);
        chk("underrun strobe count", 512'(st_cyc.size()), 512'(base + 1));
        if (st_cyc.size() > base) begin
            chk("underrun block0", st_msg[base], c);
            chk("underrun m_first", 512'(st_first[base]), 512'(1));
            chk("underrun m_last", 512'(st_last[base]), 512'(0));
        end
        chk("underrun chain_err", 512'(chain_err), 512'(1));

        w = {};
        for (int i = 0; i < 5; i++) w.push_back($urandom);
        lb = 2'($urandom);
        add_expect(w, lb);
        base = st_cyc.size();
        send_msg(w, lb, 1, acc);
        check_msgs("after underrun", base);
        chk("chain_err sticky", 512'(chain_err), 512'(1));

        // Reset in the middle of a message
        base = st_cyc.size();
        for (int i = 0; i < 10; i++) send_word($urandom, 1'b0, 2'd0, acc);
        reset = 1'b1;
        @(negedge clk);
        chk("mid reset s_ready", 512'(s_ready), 512'(0));
        @(negedge clk);
        reset = 1'b0;
        have_ref = 1'b0;
        @(negedge clk);
        chk("after reset s_ready", 512'(s_ready), 512'(1));
        chk("after reset chain_err", 512'(chain_err), 512'(0));
        repeat (5) @(negedge clk);
        chk("mid reset no strobe", 512'(st_cyc.size()), 512'(base));

        w = {32'h61626300};
        add_expect(w, 2'd3);
        base = st_cyc.size();
        send_msg(w, 2'd3, 0, acc);
        check_msgs("abc after reset", base);
`ifdef SHA_PAD_BYTE_EN
        c = {32'h61626380, 448'd0, 32'h00000018};
`else
        c = {32'h61626300, 32'h80000000, 416'd0, 32'h00000020};
`endif
        if (st_cyc.size() > base) begin
            chk("abc after reset fixed", st_msg[base], c);
            chk("abc after reset latency", 512'(st_cyc[base] - acc), 512'(2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
